dma_loader_engine: RTL and testbench
====================================

Name: dma_loader_engine

Overview:
- Parametrised successor to the single-target UART loader: a DMA engine that reassembles UART RX bytes into WORD_BYTES-wide little-endian words and writes them to one of NUM_TARGETS memories.
- A framed protocol adds a target-select byte, a configurable-width size header, an XOR checksum, an inter-byte timeout and ACK/NAK responses.
- Sits behind the debug arbiter. It owns the UART RX/TX path while grant_i is high.

Parameters:
- WORD_BYTES, 4, bytes per memory word; word width is 8*WORD_BYTES.
- ADDR_W, 32, memory address width.
- COUNT_BYTES, 2, bytes in the word-count header, big-endian; count width is 8*COUNT_BYTES.
- NUM_TARGETS, 2, number of memories; target id 0..NUM_TARGETS-1.
- TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes once a frame has started.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- grant_i  in  1  arbiter enable; level, held for the whole transfer
- done_o  out  1  high in S_DONE until grant_i drops
- error_o  out  1  valid while done_o=1; 1 = NAK was sent
- rx_data_i  in  8  received byte
- rx_ready_i  in  1  one-cycle strobe, rx_data_i valid
- tx_data_o  out  8  response byte
- tx_start_o  out  1  one-cycle start pulse
- tx_done_i  in  1  TX finished pulse
- mem_we_o  out  NUM_TARGETS  one-hot write enable
- mem_addr_o  out  ADDR_W  byte address
- mem_data_o  out  8*WORD_BYTES  write data

Behaviour:
- Reset state: S_IDLE.
  - All outputs are 0 and tx_data_o=8'h00.
  - Counters, word buffer, checksum and captured target are cleared.
- Frame format: TARGET byte, then COUNT_BYTES size bytes (MSB first), then count*WORD_BYTES payload bytes (LSB first within each word), then one CHK byte.
  - CHK equals the XOR of all payload bytes. The checksum does not cover the header.
- S_IDLE:
  - On grant_i, clear addr, processed count, byte index and checksum, then go to S_TARGET.
- S_TARGET:
  - Waits indefinitely for rx_ready_i and captures the target id.
  - An id >= NUM_TARGETS sets a sticky bad_target flag. The frame is still consumed, but no writes are issued.
- S_SIZE:
  - Shifts in COUNT_BYTES bytes.
  - After the last byte, go to S_CHECK if count==0, otherwise S_PAYLOAD.
- S_PAYLOAD:
  - Each byte goes into slot byte_index and is XORed into the checksum.
  - After byte WORD_BYTES-1, go to S_WRITE and reset byte_index.
- S_WRITE (exactly 1 cycle):
  - mem_we_o[target]=1 unless bad_target.
  - mem_addr_o=addr and mem_data_o=buffer, both valid in the same cycle.
  - addr += WORD_BYTES, wrapping mod 2^ADDR_W.
  - processed+1: if it equals count, go to S_CHECK; otherwise go to S_PAYLOAD.
  - A byte arriving during S_WRITE is not dropped; it is captured as slot 0 of the next word.
- S_CHECK:
  - On rx_ready_i, compare the byte with the checksum.
  - Set ok = match AND !bad_target, then go to S_SEND.
- S_SEND (1 cycle):
  - tx_start_o=1.
  - tx_data_o = 8'hF1 if ok, 8'hE1 on mismatch or bad target, 8'hE2 on timeout.
- S_WAIT_TX:
  - Holds tx_data_o and goes to S_DONE on tx_done_i.
- S_DONE:
  - done_o=1 and error_o=!ok.
  - Go to S_IDLE when grant_i=0.
- Writes already issued are not rolled back on NAK.
- Timeout:
  - An idle counter runs in S_SIZE, S_PAYLOAD and S_CHECK. It is cleared on every rx_ready_i and on each state entry from S_TARGET.
  - Reaching TIMEOUT_CYCLES forces S_SEND with the 8'hE2 code and ok=0.
- Grant loss: grant_i=0 in any state other than S_IDLE or S_DONE aborts to S_IDLE next cycle. No TX and no done_o are issued, and internal state is cleared.
- rx_ready_i is ignored in S_IDLE, S_SEND, S_WAIT_TX and S_DONE.
- An asynchronous reset mid-frame returns to the reset state immediately. Any write in progress that cycle is deasserted.

Test Plan:
1. Defaults, target 0, size 00 02, payload 13 00 00 00 93 00 10 00, CHK 90 -> mem_we_o=2'b01 writes 0x00000013 at addr 0 and 0x00100093 at addr 4; tx_data_o=F1; done_o=1, error_o=0.
2. Same frame with target 1 and CHK 91 -> both words are written with mem_we_o=2'b10; tx_data_o=E1; error_o=1.
3. Target 5 with size 00 01 and any 4 bytes plus a matching CHK -> mem_we_o stays 0; E1 is sent.
4. Target 0, size 00 00, CHK 00 -> no writes; F1 is sent.
5. TIMEOUT_CYCLES=50, send 3 payload bytes, then stop -> E2 is sent within 52 cycles of the last byte; error_o=1.
6. Drop grant_i after 2 payload bytes -> S_IDLE next cycle with no tx_start_o. A following new grant with a fresh frame succeeds with a write at addr 0.

Source files
------------

// File: rtl/dma_loader_engine.sv
// Framed UART-to-memory DMA loader: reassembles little-endian words from RX bytes,
// writes them to one of NUM_TARGETS memories and answers ACK/NAK/timeout on TX.
module dma_loader_engine #(
  parameter int WORD_BYTES     = 4,
  parameter int ADDR_W         = 32,
  parameter int COUNT_BYTES    = 2,
  parameter int NUM_TARGETS    = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    grant_i,
  output logic                    done_o,
  output logic                    error_o,
  input  logic [7:0]              rx_data_i,
  input  logic                    rx_ready_i,
  output logic [7:0]              tx_data_o,
  output logic                    tx_start_o,
  input  logic                    tx_done_i,
  output logic [NUM_TARGETS-1:0]  mem_we_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [8*WORD_BYTES-1:0] mem_data_o
);
  localparam int WW  = 8 * WORD_BYTES;
  localparam int CW  = 8 * COUNT_BYTES;
  localparam int BIW = $clog2(WORD_BYTES) + 1;
  localparam int SIW = $clog2(COUNT_BYTES) + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] ACK = 8'hF1, NAK = 8'hE1, TMO = 8'hE2;

  typedef enum logic [3:0] {
    S_IDLE, S_TARGET, S_SIZE, S_PAYLOAD, S_WRITE, S_CHECK, S_SEND, S_WAIT_TX, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [7:0]        target_q;
  logic              bad_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     processed_q;
  logic [SIW-1:0]    size_idx_q;
  logic [BIW-1:0]    byte_idx_q;
  logic [WW-1:0]     buf_q;
  logic [7:0]        chk_q;
  logic [ADDR_W-1:0] addr_q;
  logic [TW-1:0]     idle_q;
  logic              ok_q;
  logic [7:0]        tx_data_q;

  // Handshakes: rx_ready_i is a one-cycle valid strobe with no back-pressure, tx_start_o
  // is a one-cycle request and tx_done_i the one-cycle completion for that request.
  logic          abort, counting, timed_out, last_size, word_full, last_word;
  logic          take_payload, take_chk;
  logic [CW-1:0] count_shift;

  assign abort       = !grant_i && (state_q != S_IDLE) && (state_q != S_DONE);
  assign counting    = (state_q == S_SIZE) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
  assign timed_out   = counting && !rx_ready_i && (idle_q == TW'(TIMEOUT_CYCLES - 1));
  assign count_shift = (count_q << 8) | CW'(rx_data_i);
  assign last_size   = (size_idx_q == SIW'(COUNT_BYTES - 1));
  assign word_full   = (byte_idx_q == BIW'(WORD_BYTES - 1));
  assign last_word   = ((processed_q + CW'(1)) == count_q);
  // A byte landing in S_WRITE belongs to the next word, or is the checksum after the last word.
  assign take_payload = rx_ready_i && ((state_q == S_PAYLOAD) || (state_q == S_WRITE && !last_word));
  assign take_chk     = rx_ready_i && ((state_q == S_CHECK) || (state_q == S_WRITE && last_word));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (grant_i) state_d = S_TARGET;
        S_TARGET:  if (rx_ready_i) state_d = S_SIZE;
        S_SIZE: begin
          if (timed_out) state_d = S_SEND;
          else if (rx_ready_i && last_size) state_d = (count_shift == '0) ? S_CHECK : S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (timed_out) state_d = S_SEND;
          else if (rx_ready_i && word_full) state_d = S_WRITE;
        end
        S_WRITE: begin
          if (last_word)                    state_d = rx_ready_i ? S_SEND : S_CHECK;
          else if (rx_ready_i && word_full) state_d = S_WRITE;
          else                              state_d = S_PAYLOAD;
        end
        S_CHECK:   if (timed_out || rx_ready_i) state_d = S_SEND;
        S_SEND:    state_d = S_WAIT_TX;
        S_WAIT_TX: if (tx_done_i) state_d = S_DONE;
        S_DONE:    if (!grant_i) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      target_q <= '0; bad_q <= 1'b0; count_q <= '0; processed_q <= '0;
      size_idx_q <= '0; byte_idx_q <= '0; buf_q <= '0; chk_q <= '0;
      addr_q <= '0; idle_q <= '0; ok_q <= 1'b0; tx_data_q <= '0;
    end else if (state_q == S_IDLE || abort) begin
      target_q <= '0; bad_q <= 1'b0; count_q <= '0; processed_q <= '0;
      size_idx_q <= '0; byte_idx_q <= '0; buf_q <= '0; chk_q <= '0;
      addr_q <= '0; idle_q <= '0; ok_q <= 1'b0; tx_data_q <= '0;
    end else begin
      if (timed_out) begin
        ok_q      <= 1'b0;
        tx_data_q <= TMO;
      end else if (counting) begin
        idle_q <= rx_ready_i ? '0 : idle_q + TW'(1);
      end
      if (state_q == S_TARGET && rx_ready_i) begin
        target_q <= rx_data_i;
        bad_q    <= bad_q | (int'(rx_data_i) >= NUM_TARGETS);
        idle_q   <= '0;
      end
      if (state_q == S_SIZE && rx_ready_i) begin
        count_q    <= count_shift;
        size_idx_q <= size_idx_q + SIW'(1);
      end
      if (state_q == S_WRITE) begin
        addr_q      <= addr_q + ADDR_W'(WORD_BYTES);
        processed_q <= processed_q + CW'(1);
      end
      if (take_payload) begin
        buf_q[8*int'(byte_idx_q) +: 8] <= rx_data_i;
        chk_q      <= chk_q ^ rx_data_i;
        byte_idx_q <= word_full ? '0 : byte_idx_q + BIW'(1);
      end
      if (take_chk) begin
        ok_q      <= (rx_data_i == chk_q) && !bad_q;
        tx_data_q <= ((rx_data_i == chk_q) && !bad_q) ? ACK : NAK;
      end
    end
  end

  assign tx_data_o = tx_data_q;

  always_comb begin
    mem_we_o   = '0;
    mem_addr_o = '0;
    mem_data_o = '0;
    tx_start_o = 1'b0;
    done_o     = 1'b0;
    error_o    = 1'b0;
    case (state_q)
      S_WRITE: begin
        mem_addr_o = addr_q;
        mem_data_o = buf_q;
        if (grant_i && !bad_q) begin
          for (int i = 0; i < NUM_TARGETS; i++) mem_we_o[i] = (target_q == 8'(i));
        end
      end
      S_SEND: tx_start_o = grant_i;
      S_DONE: begin
        done_o  = 1'b1;
        error_o = !ok_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_dma_loader_engine.sv
// Directed bench for dma_loader_engine: a write scoreboard and a response scoreboard
// are filled by the frame driver and drained by monitors watching the memory and TX ports.
module tb_dma_loader_engine;
  localparam int W = 66;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        grant = 1'b0;
  logic        done_o, error_o;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic [7:0]  tx_data_o;
  logic        tx_start_o;
  logic        tx_done = 1'b0;
  logic [1:0]  mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;

  logic [W-1:0] exp_q[$];
  logic [7:0]   rsp_q[$];
  logic [7:0]   pl[$];
  int n_cmp = 0;
  int n_err = 0;
  int gap_max = 2;

  dma_loader_engine #(.WORD_BYTES(4), .ADDR_W(32), .COUNT_BYTES(2), .NUM_TARGETS(2),
                      .TIMEOUT_CYCLES(50)) dut (
    .clk_i(clk), .rst_ni(rst_n), .grant_i(grant), .done_o(done_o), .error_o(error_o),
    .rx_data_i(rx_data), .rx_ready_i(rx_ready), .tx_data_o(tx_data_o),
    .tx_start_o(tx_start_o), .tx_done_i(tx_done), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // memory write monitor
  always @(negedge clk) begin
    if (mem_we_o != 2'b00) begin
      if (exp_q.size() == 0) check("wr_unexpected", {mem_we_o, mem_addr_o, mem_data_o}, W'(0));
      else check("wr", {mem_we_o, mem_addr_o, mem_data_o}, exp_q.pop_front());
    end
  end

  // TX monitor and TX completion responder
  always @(negedge clk) begin
    if (tx_start_o) begin
      if (rsp_q.size() == 0) check("tx_unexpected", W'(tx_start_o), W'(0));
      else check("tx_code", W'(tx_data_o), W'(rsp_q.pop_front()));
      repeat (2) @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    repeat ($urandom_range(gap_max, 0)) tick();
  endtask

  task automatic start_grant();
    grant = 1'b1;
    tick();
  endtask

  task automatic wait_done(input logic [7:0] code, input logic err);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done_o) break;
    end
    check("done", W'(done_o), W'(1));
    check("error", W'(error_o), W'(err));
    check("tx_hold", W'(tx_data_o), W'(code));
    check("wr_left", W'(exp_q.size()), W'(0));
    check("rsp_left", W'(rsp_q.size()), W'(0));
    exp_q.delete();
    rsp_q.delete();
    grant = 1'b0;
    tick();
    @(negedge clk);
    check("done_clr", W'(done_o), W'(0));
    tick();
  endtask

  // Drives a full frame from pl; expected writes and response come from the bench model.
  task automatic run_frame(input logic [7:0] tgt, input logic [15:0] cnt, input logic [7:0] chk);
    logic [7:0]  x;
    logic [7:0]  code;
    logic [1:0]  we;
    logic [31:0] w;
    x = 8'h00;
    foreach (pl[i]) x ^= pl[i];
    code = (tgt < 8'd2 && chk == x) ? 8'hF1 : 8'hE1;
    we = 2'b01 << tgt;
    if (tgt < 8'd2) begin
      for (int k = 0; k < int'(cnt); k++) begin
        w = {pl[4*k+3], pl[4*k+2], pl[4*k+1], pl[4*k]};
        exp_q.push_back({we, 32'(4*k), w});
      end
    end
    rsp_q.push_back(code);
    start_grant();
    send_byte(tgt);
    send_byte(cnt[15:8]);
    send_byte(cnt[7:0]);
    foreach (pl[i]) send_byte(pl[i]);
    send_byte(chk);
    wait_done(code, code != 8'hF1);
  endtask

  initial begin
    logic [7:0] x;
    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", W'(done_o), W'(0));
    check("rst_error", W'(error_o), W'(0));
    check("rst_tx_data", W'(tx_data_o), W'(0));
    check("rst_tx_start", W'(tx_start_o), W'(0));
    check("rst_we", W'(mem_we_o), W'(0));
    check("rst_addr", W'(mem_addr_o), W'(0));
    check("rst_data", W'(mem_data_o), W'(0));
    rst_n = 1'b1;
    tick();

    // 1: target 0, two words, good checksum
    pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_frame(8'd0, 16'd2, 8'h90);
    // 2: target 1, bad checksum
    run_frame(8'd1, 16'd2, 8'h91);
    // 3: bad target with matching checksum
    pl = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
    run_frame(8'd5, 16'd1, 8'hA5 ^ 8'h5A ^ 8'h3C ^ 8'hC3);
    // 4: empty frame
    pl.delete();
    run_frame(8'd0, 16'd0, 8'h00);

    // 5: inter-byte timeout after 3 payload bytes
    gap_max = 0;
    rsp_q.push_back(8'hE2);
    start_grant();
    send_byte(8'd0); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 52; k++) begin
        @(negedge clk);
        if (tx_start_o) begin
          seen = 1'b1;
          break;
        end
      end
      check("tmo_latency", W'(seen), W'(1));
    end
    wait_done(8'hE2, 1'b1);

    // 6: grant loss mid-payload, no TX and no done
    start_grant();
    send_byte(8'd0); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h44); send_byte(8'h55);
    grant = 1'b0;
    tick();
    repeat (10) begin
      @(negedge clk);
      check("abort_done", W'(done_o), W'(0));
    end
    tick();
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(8'd0, 16'd1, 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04);

    // asynchronous reset while a write is on the port
    start_grant();
    send_byte(8'd0); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    #1 rst_n = 1'b0;
    #1;
    check("arst_we", W'(mem_we_o), W'(0));
    check("arst_tx_start", W'(tx_start_o), W'(0));
    grant = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // random three-word frame to target 1
    gap_max = 3;
    pl.delete();
    x = 8'h00;
    for (int i = 0; i < 12; i++) begin
      pl.push_back(8'($urandom_range(255, 0)));
      x ^= pl[i];
    end
    run_frame(8'd1, 16'd3, x);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
